// File: rtl/pci_target.sv
// rtl/pci_target.sv - PCI-style bus target with a small word memory and burst read/write support
module pci_target #(
    parameter logic [1:0] DEV_ADDR = 2'b00,
    parameter int         DEPTH    = 4,
    parameter int         PTR_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] d,
    input  logic [3:0]  C_BE,
    input  logic        frame,
    input  logic        irdy,
    inout  wire         trdy,
    inout  wire         devsel
);

    typedef enum logic [2:0] {IDLE, BUSY, W_DATA, R_TURN, R_DATA, RELEASE} state_t;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [31:0]        mem [DEPTH];
    logic               frame_q;
    logic               bus_oe;
    logic               trdy_o;
    logic               devsel_o;
    logic               d_oe;
    logic               addr_phase;
    logic               hit;

    // Falling edge of frame marks the address phase; frame_q remembers last cycle's level.
    assign addr_phase = !frame && frame_q;
    assign hit        = (d[1:0] == DEV_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            frame_q  <= 1'b1;
            bus_oe   <= 1'b0;
            trdy_o   <= 1'b1;
            devsel_o <= 1'b1;
            d_oe     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            frame_q <= frame;
            case (state)
                IDLE: begin
                    if (addr_phase) begin
                        ptr <= '0;
                        if (hit && C_BE == CMD_MEM_WRITE) begin
                            state    <= W_DATA;
                            bus_oe   <= 1'b1;
                            devsel_o <= 1'b0;
                            trdy_o   <= 1'b0;
                        end else if (hit && C_BE == CMD_MEM_READ) begin
                            state    <= R_TURN;
                            bus_oe   <= 1'b1;
                            devsel_o <= 1'b0;
                            trdy_o   <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (frame && irdy) state <= IDLE;
                end
                W_DATA: begin
                    if (!irdy) begin
                        for (int i = 0; i < 4; i++)
                            if (C_BE[i]) mem[ptr][8*i +: 8] <= d[8*i +: 8];
                        ptr <= ptr + 1'b1;
                    end
                    // frame high ends the burst whether or not this edge transferred
                    if (frame) begin
                        state    <= RELEASE;
                        devsel_o <= 1'b1;
                        trdy_o   <= 1'b1;
                    end
                end
                R_TURN: begin
                    if (frame && irdy) begin
                        state    <= RELEASE;
                        devsel_o <= 1'b1;
                        trdy_o   <= 1'b1;
                    end else begin
                        state  <= R_DATA;
                        trdy_o <= 1'b0;
                        d_oe   <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (!irdy) ptr <= ptr + 1'b1;
                    if (frame) begin
                        state    <= RELEASE;
                        devsel_o <= 1'b1;
                        trdy_o   <= 1'b1;
                        d_oe     <= 1'b0;
                    end
                end
                RELEASE: begin
                    state  <= IDLE;
                    bus_oe <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign d      = d_oe   ? mem[ptr] : 'z;
    assign trdy   = bus_oe ? trdy_o   : 1'bz;
    assign devsel = bus_oe ? devsel_o : 1'bz;

endmodule

// File: tb/tb_pci_target.sv
// tb/tb_pci_target.sv - scoreboard bench for pci_target; pulled-up bus makes released lines read as 1
module tb_pci_target;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  C_BE = 4'h0;
    logic        frame = 1'b1;
    logic        irdy = 1'b1;
    logic [31:0] tb_d = '0;
    logic        tb_d_oe = 1'b0;

    tri1 [31:0]  d;
    tri1         trdy;
    tri1         devsel;

    assign d = tb_d_oe ? tb_d : 'z;

    always #5 clk = ~clk;

    pci_target #(.DEV_ADDR(2'b01), .DEPTH(4), .PTR_W(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .d      (d),
        .C_BE   (C_BE),
        .frame  (frame),
        .irdy   (irdy),
        .trdy   (trdy),
        .devsel (devsel)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    logic [31:0] wbuf [8];
    logic [31:0] rbuf [8];

    localparam logic [31:0] ZBUS = 32'hFFFF_FFFF;
    localparam logic [31:0] HIT  = 32'h0000_1001;
    localparam logic [31:0] MISS = 32'h0000_2002;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Read-data monitor: every completed read transfer must match the next queued word.
    always @(negedge clk) begin
        if (!reset && !tb_d_oe && irdy === 1'b0 && trdy === 1'b0 && devsel === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got %h expected no transfer", d);
            end else begin
                chk("rd_data", d, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic f, input logic i, input logic oe,
                         input logic [31:0] dv, input logic [3:0] be);
        frame = f; irdy = i; tb_d_oe = oe; tb_d = dv; C_BE = be;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] addr, input logic [3:0] cmd);
        drive(1'b0, 1'b1, 1'b1, addr, cmd);
        @(negedge clk);
        chk_bit("addr_devsel_z", devsel, 1'b1);
        chk_bit("addr_trdy_z", trdy, 1'b1);
        next_cycle();
    endtask

    task automatic release_cycle(input string tag);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk_bit({tag, "_rel_devsel"}, devsel, 1'b1);
        chk_bit({tag, "_rel_trdy"}, trdy, 1'b1);
        chk({tag, "_rel_d_z"}, d, ZBUS);
        next_cycle();
    endtask

    task automatic write_burst(input int n, input logic [3:0] be, input int wait_at, input int wait_n);
        addr_phase(HIT, 4'b0111);
        for (int i = 0; i < n; i++) begin
            if (i == wait_at) begin
                for (int k = 0; k < wait_n; k++) begin
                    drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, be);
                    @(negedge clk);
                    chk_bit("wr_wait_trdy", trdy, 1'b0);
                    next_cycle();
                end
            end
            drive(i == n - 1, 1'b0, 1'b1, wbuf[i], be);
            @(negedge clk);
            chk_bit("wr_devsel", devsel, 1'b0);
            chk_bit("wr_trdy", trdy, 1'b0);
            next_cycle();
        end
        release_cycle("wr");
    endtask

    task automatic read_burst(input int n, input int wait_at, input int wait_n);
        for (int i = 0; i < n; i++) exp_q.push_back(rbuf[i]);
        addr_phase(HIT, 4'b0110);
        drive(n == 1, 1'b0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk_bit("turn_devsel", devsel, 1'b0);
        chk_bit("turn_trdy", trdy, 1'b1);
        chk("turn_d_z", d, ZBUS);
        next_cycle();
        for (int i = 0; i < n; i++) begin
            if (i == wait_at) begin
                for (int k = 0; k < wait_n; k++) begin
                    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
                    @(negedge clk);
                    chk("rd_wait_hold", d, rbuf[i]);
                    next_cycle();
                end
            end
            drive(i == n - 1, 1'b0, 1'b0, 32'h0, 4'h0);
            next_cycle();
        end
        release_cycle("rd");
    endtask

    task automatic miss_txn(input logic [31:0] addr, input logic [3:0] cmd, input int n);
        addr_phase(addr, cmd);
        for (int i = 0; i < n; i++) begin
            drive(i == n - 1, 1'b0, cmd == 4'b0111, 32'h1111_1111, 4'hF);
            @(negedge clk);
            chk_bit("miss_devsel", devsel, 1'b1);
            chk_bit("miss_trdy", trdy, 1'b1);
            if (cmd != 4'b0111) chk("miss_d_z", d, ZBUS);
            next_cycle();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        next_cycle();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_bit("rst_devsel", devsel, 1'b1);
        chk_bit("rst_trdy", trdy, 1'b1);
        chk("rst_d", d, ZBUS);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 4; i++) rbuf[i] = 32'h0;
        read_burst(4, -1, 0);

        wbuf[0] = 32'hAAAA_AAAA; wbuf[1] = 32'hBBBB_BBBB; wbuf[2] = 32'hCCCC_CCCC;
        write_burst(3, 4'hF, -1, 0);

        rbuf[0] = 32'hAAAA_AAAA; rbuf[1] = 32'hBBBB_BBBB; rbuf[2] = 32'hCCCC_CCCC;
        read_burst(3, -1, 0);

        miss_txn(MISS, 4'b0111, 2);
        miss_txn(MISS, 4'b0110, 2);
        miss_txn(HIT, 4'b0010, 1);
        read_burst(3, -1, 0);

        wbuf[0] = 32'h1234_5678;
        write_burst(1, 4'b0101, -1, 0);
        rbuf[0] = 32'hAA34_AA78;
        read_burst(1, -1, 0);

        wbuf[0] = 32'h0101_0101; wbuf[1] = 32'h0202_0202; wbuf[2] = 32'h0303_0303;
        wbuf[3] = 32'h0404_0404; wbuf[4] = 32'h0505_0505;
        write_burst(5, 4'hF, 2, 2);
        rbuf[0] = 32'h0505_0505; rbuf[1] = 32'h0202_0202; rbuf[2] = 32'h0303_0303;
        rbuf[3] = 32'h0404_0404; rbuf[4] = 32'h0505_0505; rbuf[5] = 32'h0202_0202;
        read_burst(6, 3, 2);

        // Reset arrives while the target is driving read data.
        exp_q.push_back(32'h0505_0505);
        addr_phase(HIT, 4'b0110);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
        next_cycle();
        @(negedge clk);
        chk_bit("mid_rst_devsel", devsel, 1'b1);
        chk_bit("mid_rst_trdy", trdy, 1'b1);
        chk("mid_rst_d", d, ZBUS);
        next_cycle();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        next_cycle();
        for (int i = 0; i < 4; i++) rbuf[i] = 32'h0;
        read_burst(4, -1, 0);

        repeat (2) next_cycle();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
